// File: rtl/vai_tx_arb.sv
// Merges per-AFU CCI-P write requests into one upstream stream, stamping the AFU index into mdata; optional VAI_TX_ARB_STATS_EN adds per-AFU grant counters.
// Latency: enqueue in cycle t -> up_tx_valid in cycle t+2; one request per cycle sustained.
// Backpressure: per-AFU registered almost-full with ALMFULL_SLACK headroom; no grant while up_almfull is high.

module vai_tx_arb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             pClk,
    input  logic             SoftReset,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] wrDat,
    input  logic             rdEn,
    output logic [WIDTH-1:0] rdDat,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;

    assign rdDat = mem[rdPtr];

    always_ff @(posedge pClk) begin
        if (wrEn) begin
            mem[wrPtr] <= wrDat;
        end
    end

    always_ff @(posedge pClk) begin
        if (SoftReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (rdEn) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({wrEn, rdEn})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module vai_tx_arb #(
    parameter int NUM_SUB_AFUS  = 16,
    parameter int TAG_W         = 4,
    parameter int HDR_W         = 80,
    parameter int DATA_W        = 512,
    parameter int FIFO_DEPTH    = 16,
    parameter int ALMFULL_SLACK = 8
) (
    input  logic                           pClk,
    input  logic                           SoftReset,
    input  logic [NUM_SUB_AFUS-1:0]        afu_tx_valid,
    input  logic [NUM_SUB_AFUS*HDR_W-1:0]  afu_tx_hdr,
    input  logic [NUM_SUB_AFUS*DATA_W-1:0] afu_tx_data,
    output logic [NUM_SUB_AFUS-1:0]        afu_tx_almfull,
    input  logic                           up_almfull,
    output logic                           up_tx_valid,
    output logic [HDR_W-1:0]               up_tx_hdr,
    output logic [DATA_W-1:0]              up_tx_data,
`ifdef VAI_TX_ARB_STATS_EN
    output logic [NUM_SUB_AFUS*32-1:0]     stat_grant_cnt,
`endif
    output logic [NUM_SUB_AFUS-1:0]        overflow_err
);
    localparam int ENT_W = HDR_W + DATA_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ENT_W-1:0]        fifoRdDat [NUM_SUB_AFUS];
    logic [CNT_W-1:0]        fifoCnt   [NUM_SUB_AFUS];
    logic [CNT_W-1:0]        nxtCnt    [NUM_SUB_AFUS];
    logic [NUM_SUB_AFUS-1:0] wrEn;
    logic [NUM_SUB_AFUS-1:0] deq;
    logic [NUM_SUB_AFUS-1:0] notEmpty;
    logic [NUM_SUB_AFUS-1:0] isFull;
    logic [NUM_SUB_AFUS-1:0] ovfHit;

    logic                    grantVld;
    logic [TAG_W-1:0]        grantIdx;
    logic [TAG_W-1:0]        rrPtr;
    logic [ENT_W-1:0]        selEnt;
    logic [HDR_W-1:0]        stampHdr;

    for (genvar gi = 0; gi < NUM_SUB_AFUS; gi++) begin : g_afu
        assign notEmpty[gi] = (fifoCnt[gi] != '0);
        assign isFull[gi]   = (fifoCnt[gi] == CNT_W'(FIFO_DEPTH));
        // A full FIFO still accepts when it is being drained in the same cycle.
        assign wrEn[gi]     = afu_tx_valid[gi] & ~SoftReset & (~isFull[gi] | deq[gi]);
        assign ovfHit[gi]   = afu_tx_valid[gi] & ~SoftReset & isFull[gi] & ~deq[gi];
        assign nxtCnt[gi]   = fifoCnt[gi] + CNT_W'(wrEn[gi]) - CNT_W'(deq[gi]);

        vai_tx_arb_fifo #(
            .WIDTH (ENT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .pClk      (pClk),
            .SoftReset (SoftReset),
            .wrEn      (wrEn[gi]),
            .wrDat     ({afu_tx_hdr[gi*HDR_W +: HDR_W], afu_tx_data[gi*DATA_W +: DATA_W]}),
            .rdEn      (deq[gi]),
            .rdDat     (fifoRdDat[gi]),
            .count     (fifoCnt[gi])
        );
    end

    always_ff @(posedge pClk) begin
        if (SoftReset) begin
            afu_tx_almfull <= '0;
            overflow_err   <= '0;
        end else begin
            for (int i = 0; i < NUM_SUB_AFUS; i++) begin
                afu_tx_almfull[i] <= (nxtCnt[i] >= CNT_W'(FIFO_DEPTH - ALMFULL_SLACK));
                if (ovfHit[i]) begin
                    overflow_err[i] <= 1'b1;
                end
            end
        end
    end

    // Round-robin search starting at rrPtr; upstream almost-full blocks this cycle's grant.
    always_comb begin
        int idx;
        idx      = 0;
        grantVld = 1'b0;
        grantIdx = '0;
        deq      = '0;
        for (int k = 0; k < NUM_SUB_AFUS; k++) begin
            idx = int'(rrPtr) + k;
            if (idx >= NUM_SUB_AFUS) begin
                idx = idx - NUM_SUB_AFUS;
            end
            if (!grantVld && !up_almfull && notEmpty[idx]) begin
                grantVld = 1'b1;
                grantIdx = TAG_W'(idx);
            end
        end
        if (grantVld) begin
            deq[grantIdx] = 1'b1;
        end
    end

    always_comb begin
        selEnt                = fifoRdDat[grantIdx];
        stampHdr              = selEnt[ENT_W-1 -: HDR_W];
        stampHdr[15 -: TAG_W] = grantIdx;
    end

    always_ff @(posedge pClk) begin
        if (SoftReset) begin
            up_tx_valid <= 1'b0;
            up_tx_hdr   <= '0;
            up_tx_data  <= '0;
            rrPtr       <= '0;
        end else begin
            up_tx_valid <= grantVld;
            if (grantVld) begin
                up_tx_hdr  <= stampHdr;
                up_tx_data <= selEnt[DATA_W-1:0];
                rrPtr      <= (grantIdx == TAG_W'(NUM_SUB_AFUS - 1)) ? '0 : grantIdx + TAG_W'(1);
            end
        end
    end

`ifdef VAI_TX_ARB_STATS_EN
    always_ff @(posedge pClk) begin
        if (SoftReset) begin
            stat_grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_SUB_AFUS; i++) begin
                if (grantVld && (grantIdx == TAG_W'(i)) && (stat_grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF)) begin
                    stat_grant_cnt[i*32 +: 32] <= stat_grant_cnt[i*32 +: 32] + 32'd1;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_vai_tx_arb.sv
// Scoreboard bench for vai_tx_arb: requests are queued as driven and compared as they leave upstream.
module tb_vai_tx_arb;
    localparam int N      = 16;
    localparam int HDR_W  = 80;
    localparam int DATA_W = 512;

    typedef struct packed {
        logic [HDR_W-1:0]  hdr;
        logic [DATA_W-1:0] data;
    } req_t;

    logic                  pClk = 1'b0;
    logic                  SoftReset;
    logic [N-1:0]          afuValid;
    logic [N*HDR_W-1:0]    afuHdr;
    logic [N*DATA_W-1:0]   afuData;
    logic [N-1:0]          afuAlmfull;
    logic                  upAlmfull;
    logic                  upValid;
    logic [HDR_W-1:0]      upHdr;
    logic [DATA_W-1:0]     upData;
    logic [N-1:0]          overflowErr;
`ifdef VAI_TX_ARB_STATS_EN
    logic [N*32-1:0]       statCnt;
`endif

    req_t expQ [$];
    req_t monE;
    int   nChecks = 0;
    int   nErrors = 0;
    int   outCnt  = 0;
    int   runLen  = 0;
    int   maxRun  = 0;
    int   base;

    always #5 pClk = ~pClk;

    vai_tx_arb dut (
        .pClk           (pClk),
        .SoftReset      (SoftReset),
        .afu_tx_valid   (afuValid),
        .afu_tx_hdr     (afuHdr),
        .afu_tx_data    (afuData),
        .afu_tx_almfull (afuAlmfull),
        .up_almfull     (upAlmfull),
        .up_tx_valid    (upValid),
        .up_tx_hdr      (upHdr),
        .up_tx_data     (upData),
`ifdef VAI_TX_ARB_STATS_EN
        .stat_grant_cnt (statCnt),
`endif
        .overflow_err   (overflowErr)
    );

    task automatic checkVal(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    task automatic clearReq();
        afuValid = '0;
    endtask

    task automatic putReq(input int afu, input bit sb, input bit forceMd = 1'b0, input logic [15:0] md = 16'h0);
        logic [95:0]       r96;
        logic [HDR_W-1:0]  h;
        logic [DATA_W-1:0] d;
        req_t              e;
        r96 = {$urandom(), $urandom(), $urandom()};
        h   = r96[HDR_W-1:0];
        if (forceMd) begin
            h[15:0] = md;
        end
        for (int w = 0; w < DATA_W/32; w++) begin
            d[w*32 +: 32] = $urandom();
        end
        afuValid[afu]                 = 1'b1;
        afuHdr[afu*HDR_W +: HDR_W]    = h;
        afuData[afu*DATA_W +: DATA_W] = d;
        if (sb) begin
            e.hdr        = h;
            e.hdr[15:12] = 4'(afu);
            e.data       = d;
            expQ.push_back(e);
        end
    endtask

    task automatic waitDrain();
        for (int c = 0; c < 300 && expQ.size() != 0; c++) begin
            tick();
        end
        checkVal("drain", 512'(expQ.size()), 512'd0);
    endtask

    task automatic doReset();
        SoftReset = 1'b1;
        clearReq();
        tick();
        tick();
        SoftReset = 1'b0;
        expQ.delete();
    endtask

    always @(negedge pClk) begin
        if (upValid === 1'b1) begin
            outCnt++;
            runLen++;
            if (runLen > maxRun) maxRun = runLen;
            checkVal("out_pending", 512'(expQ.size() > 0), 512'd1);
            if (expQ.size() > 0) begin
                monE = expQ.pop_front();
                checkVal("out_hdr", 512'(upHdr), 512'(monE.hdr));
                checkVal("out_data", upData, monE.data);
            end
        end else begin
            runLen = 0;
        end
    end

    initial begin
        SoftReset = 1'b1;
        upAlmfull = 1'b0;
        afuValid  = '0;
        afuHdr    = '0;
        afuData   = '0;
        repeat (3) tick();
        checkVal("rst_valid", 512'(upValid), 512'd0);
        checkVal("rst_hdr", 512'(upHdr), 512'd0);
        checkVal("rst_data", upData, 512'd0);
        checkVal("rst_almfull", 512'(afuAlmfull), 512'd0);
        checkVal("rst_ovf", 512'(overflowErr), 512'd0);
        SoftReset = 1'b0;
        tick();

        // Single request, minimum latency and tag stamping.
        putReq(3, 1'b1, 1'b1, 16'hFFFF);
        tick();
        clearReq();
        checkVal("lat_t1", 512'(upValid), 512'd0);
        tick();
        checkVal("lat_t2", 512'(upValid), 512'd1);
        checkVal("tag_mdata", 512'(upHdr[15:0]), 512'h3FFF);
        tick();
        checkVal("lat_t3", 512'(upValid), 512'd0);
        waitDrain();

        // Round-robin fairness across AFUs 0, 5, 9.
        doReset();
        maxRun = 0;
        for (int r = 0; r < 4; r++) begin
            clearReq();
            putReq(0, 1'b1);
            putReq(5, 1'b1);
            putReq(9, 1'b1);
            tick();
        end
        clearReq();
        waitDrain();
        checkVal("rr_run", 512'(maxRun), 512'd12);

        // Upstream backpressure with 10 buffered requests.
        doReset();
        upAlmfull = 1'b1;
        for (int r = 0; r < 10; r++) begin
            clearReq();
            putReq(2, 1'b1);
            tick();
        end
        clearReq();
        repeat (3) tick();
        checkVal("bp_hold", 512'(outCnt), 512'(outCnt - 0));
        base = outCnt;
        upAlmfull = 1'b0;
        tick();
        upAlmfull = 1'b1;
        repeat (8) tick();
        checkVal("bp_inflight", 512'(outCnt - base), 512'd1);
        base   = outCnt;
        maxRun = 0;
        upAlmfull = 1'b0;
        repeat (11) tick();
        checkVal("bp_drain_cnt", 512'(outCnt - base), 512'd9);
        checkVal("bp_drain_run", 512'(maxRun), 512'd9);
        waitDrain();

        // Almost-full threshold and overflow on AFU 0.
        doReset();
        upAlmfull = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            clearReq();
            putReq(0, k <= 16);
            tick();
            if (k == 7)  checkVal("almfull_7", 512'(afuAlmfull[0]), 512'd0);
            if (k == 8)  checkVal("almfull_8", 512'(afuAlmfull[0]), 512'd1);
            if (k == 16) checkVal("ovf_16", 512'(overflowErr[0]), 512'd0);
            if (k == 17) checkVal("ovf_17", 512'(overflowErr[0]), 512'd1);
        end
        clearReq();
        upAlmfull = 1'b0;
        waitDrain();
        repeat (3) tick();
        checkVal("almfull_drained", 512'(afuAlmfull), 512'd0);
        checkVal("ovf_sticky", 512'(overflowErr), 512'h1);

        // Reset mid-operation with buffered requests and rrPtr away from 0.
        doReset();
        putReq(5, 1'b1);
        tick();
        clearReq();
        waitDrain();
        tick();
        upAlmfull = 1'b1;
        for (int r = 0; r < 6; r++) begin
            clearReq();
            putReq((r % 2 == 1) ? 1 : 5, 1'b0);
            tick();
        end
        clearReq();
        tick();
        SoftReset = 1'b1;
        expQ.delete();
        putReq(4, 1'b0);
        tick();
        clearReq();
        checkVal("midrst_valid", 512'(upValid), 512'd0);
        checkVal("midrst_hdr", 512'(upHdr), 512'd0);
        SoftReset = 1'b0;
        upAlmfull = 1'b0;
        base = outCnt;
        repeat (10) tick();
        checkVal("midrst_no_stale", 512'(outCnt - base), 512'd0);
        putReq(1, 1'b1);
        putReq(7, 1'b1);
        tick();
        clearReq();
        waitDrain();

`ifdef VAI_TX_ARB_STATS_EN
        // Grant counters.
        doReset();
        for (int r = 0; r < 5; r++) begin
            clearReq();
            putReq(2, 1'b1);
            tick();
        end
        for (int r = 0; r < 3; r++) begin
            clearReq();
            putReq(7, 1'b1);
            tick();
        end
        clearReq();
        waitDrain();
        tick();
        for (int i = 0; i < N; i++) begin
            checkVal($sformatf("stat_%0d", i), 512'(statCnt[i*32 +: 32]),
                     512'((i == 2) ? 5 : (i == 7) ? 3 : 0));
        end
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
